// File: rtl/feeder_pkg.sv
// Shared definitions for the instruction feeder: word width and the
// issue FSM state encoding used by instr_feeder.
package feeder_pkg;

  // Width of one CPU instruction word.
  localparam int INSTR_W = 32;

  // Issue handshake states:
  //   IDLE  - nothing presented, waiting for an idle CPU and a queued word
  //   ISSUE - word presented on instr, waiting for the CPU to start on it
  //   EXEC  - CPU busy with the word, waiting for it to go idle again
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2
  } state_t;

endpackage : feeder_pkg

// File: rtl/instr_fifo.sv
// Instruction word FIFO for instr_feeder.
// Power-of-two depth, pointers wrap naturally in AW bits. A push is taken
// only when the FIFO was not full before the edge (a same-cycle pop never
// makes room), a pop only when it was not empty before the edge (a word
// pushed into an empty FIFO is poppable from the following cycle). flush
// clears pointers/occupancy and suppresses any same-cycle push and pop.
// DEPTH must be a power of two in 2..256.
module instr_fifo
  import feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic [INSTR_W-1:0] i_push_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [INSTR_W-1:0] o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [AW:0]        o_level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_level;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  // Status comes straight from the occupancy register, so no input reaches
  // these outputs combinationally.
  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);

  // Qualify requests against pre-edge occupancy; flush overrides both.
  assign w_push_ok = i_push && !w_full  && !i_flush;
  assign w_pop_ok  = i_pop  && !w_empty && !i_flush;

  // Storage write; contents need no reset because pointers gate every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= r_level + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

  // Head word is read from the registered read pointer; the consumer
  // captures it into its own register on the pop edge.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule : instr_fifo

// File: rtl/instr_feeder.sv
// Instruction feeder: a host pushes instruction words into a FIFO and this
// block hands them one at a time to a CPU using a three-state handshake on
// cpu_waiting (IDLE -> ISSUE -> EXEC -> IDLE). instr is registered and holds
// its value until the next issue (or reset). overflow is sticky until rst.
// Optional feature macro: INSTR_FEEDER_COUNT_EN adds a 32-bit issue_count
// output counting IDLE->ISSUE transitions (cleared by rst only).
module instr_feeder
  import feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               host_wr_en,
  input  logic [INSTR_W-1:0] host_wr_data,
  input  logic               flush,
  input  logic               cpu_waiting,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level,
  output logic               overflow,
  output logic               drained
`ifdef INSTR_FEEDER_COUNT_EN
  ,
  output logic [31:0]        issue_count
`endif
);

  state_t             r_state;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_valid;
  logic               r_overflow;
  logic               r_cpu_waiting;

  logic               w_pop;
  logic [INSTR_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic [AW:0]        w_level;

  // A word leaves the FIFO only from IDLE with an idle CPU; flush wins.
  assign w_pop = (r_state == IDLE) && cpu_waiting && !w_empty && !flush;

  instr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (host_wr_en),
    .i_push_data (host_wr_data),
    .i_pop       (w_pop),
    .i_flush     (flush),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  // Issue FSM with registered instr/instr_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_instr       <= w_head;
            r_instr_valid <= 1'b1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          // flush withdraws the presented word but leaves instr untouched.
          if (flush) begin
            r_instr_valid <= 1'b0;
            r_state       <= IDLE;
          end else if (!cpu_waiting) begin
            r_instr_valid <= 1'b0;
            r_state       <= EXEC;
          end
        end
        EXEC: begin
          // The CPU is already running a word; flush does not interrupt it.
          if (cpu_waiting) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_instr_valid <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  // Sticky record of any push attempted while the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (host_wr_en && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  // Registered copy of cpu_waiting so drained has no input-to-output path;
  // drained therefore reflects cpu_waiting as sampled at the last edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_waiting <= 1'b0;
    end else begin
      r_cpu_waiting <= cpu_waiting;
    end
  end

`ifdef INSTR_FEEDER_COUNT_EN
  logic [31:0] r_issue_count;

  // Count every IDLE->ISSUE transition; wraps naturally, flush has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_count <= '0;
    end else if (w_pop) begin
      r_issue_count <= r_issue_count + 32'd1;
    end
  end

  assign issue_count = r_issue_count;
`endif

  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign level       = w_level;
  assign overflow    = r_overflow;
  assign drained     = w_empty && (r_state == IDLE) && r_cpu_waiting;

endmodule : instr_feeder
